// File: rtl/byte_result_pipe_pkg.sv
// Shared byte-unit constants: writeback latency, stage field widths and a
// helper to count live stages.
package byte_result_pipe_pkg;

    localparam int BYTE_LAT = 4;
    localparam int RT_W     = 7;
    localparam int DATA_W   = 128;
    localparam int CNT_W    = 3;

    function automatic logic [CNT_W-1:0] count_valid(input logic [7:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/byte_pipe_stage.sv
// One byte-result pipeline stage: valid bit plus payload, with hold and kill.
module byte_pipe_stage #(
    parameter int PW = 136
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          kill,
    input  logic          d_valid,
    input  logic [PW-1:0] d_payload,
    output logic          q_valid,
    output logic [PW-1:0] q_payload
);

    // kill drops only the valid bit; the payload is left as-is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid   <= 1'b0;
            q_payload <= '0;
        end else if (kill) begin
            q_valid   <= 1'b0;
        end else if (!hold) begin
            q_valid   <= d_valid;
            q_payload <= d_payload;
        end
    end

endmodule

// File: rtl/byte_result_pipe.sv
// Byte-ALU result pipeline: LATENCY stages to register writeback, with
// per-stage forwarding taps enabled by `define BYTE_PIPE_FWD_EN.
module byte_result_pipe
    import byte_result_pipe_pkg::*;
#(
    parameter int LATENCY = BYTE_LAT,
    parameter int ADDR_W  = RT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_reg_wr,
    input  logic [ADDR_W-1:0]          in_rt_addr,
    input  logic [DATA_W-1:0]          in_result,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       in_ready,
    output logic [LATENCY-1:0]         fw_valid,
    output logic [ADDR_W*LATENCY-1:0]  fw_rt_addr,
    output logic [DATA_W*LATENCY-1:0]  fw_data,
    output logic                       wb_valid,
    output logic [ADDR_W-1:0]          wb_rt_addr,
    output logic [DATA_W-1:0]          wb_data,
    output logic [CNT_W-1:0]           inflight
);

    localparam int PW = 1 + ADDR_W + DATA_W;

    // index 0 is the issue slot, k is stage k
    logic [LATENCY:0]         vld_pipe;
    logic [LATENCY:0][PW-1:0] pl_pipe;
    logic [CNT_W-1:0]         cnt_nxt;

    assign in_ready    = !stall;
    assign vld_pipe[0] = in_valid;
    assign pl_pipe[0]  = {in_reg_wr, in_rt_addr, in_result};

    for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
        byte_pipe_stage #(.PW(PW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .hold      (stall),
            .kill      (flush),
            .d_valid   (vld_pipe[k-1]),
            .d_payload (pl_pipe[k-1]),
            .q_valid   (vld_pipe[k]),
            .q_payload (pl_pipe[k])
        );
    end

    // next occupancy = whatever shifts into stages 1..LATENCY this edge
    always_comb begin
        cnt_nxt = inflight;
        if (flush)
            cnt_nxt = '0;
        else if (!stall)
            cnt_nxt = count_valid(8'(vld_pipe[LATENCY-1:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= '0;
        else        inflight <= cnt_nxt;
    end

    assign wb_valid   = vld_pipe[LATENCY] & pl_pipe[LATENCY][PW-1];
    assign wb_rt_addr = pl_pipe[LATENCY][DATA_W +: ADDR_W];
    assign wb_data    = pl_pipe[LATENCY][DATA_W-1:0];

`ifdef BYTE_PIPE_FWD_EN
    // stage 1 lands in fw_valid[0] and in the MSBs of the packed buses
    for (genvar k = 1; k <= LATENCY; k++) begin : g_fwd
        assign fw_valid[k-1] = vld_pipe[k] & pl_pipe[k][PW-1];
        assign fw_rt_addr[ADDR_W*(LATENCY-k+1)-1 -: ADDR_W] = pl_pipe[k][DATA_W +: ADDR_W];
        assign fw_data[DATA_W*(LATENCY-k+1)-1 -: DATA_W]    = pl_pipe[k][DATA_W-1:0];
    end
`else
    assign fw_valid   = '0;
    assign fw_rt_addr = '0;
    assign fw_data    = '0;
`endif

endmodule

// File: tb/tb_byte_result_pipe.sv
// Scoreboard bench for byte_result_pipe: expected writebacks (with due cycle)
// are queued at issue and matched against wb_* by a negedge monitor.
module tb_byte_result_pipe;
    import byte_result_pipe_pkg::*;

    localparam int LAT = BYTE_LAT;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_reg_wr = 1'b0;
    logic [RT_W-1:0]         in_rt_addr = '0;
    logic [DATA_W-1:0]       in_result = '0;
    logic                    stall = 1'b0;
    logic                    flush = 1'b0;
    logic                    in_ready;
    logic [LAT-1:0]          fw_valid;
    logic [RT_W*LAT-1:0]     fw_rt_addr;
    logic [DATA_W*LAT-1:0]   fw_data;
    logic                    wb_valid;
    logic [RT_W-1:0]         wb_rt_addr;
    logic [DATA_W-1:0]       wb_data;
    logic [CNT_W-1:0]        inflight;

    byte_result_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_wr(in_reg_wr),
        .in_rt_addr(in_rt_addr), .in_result(in_result), .stall(stall), .flush(flush),
        .in_ready(in_ready), .fw_valid(fw_valid), .fw_rt_addr(fw_rt_addr), .fw_data(fw_data),
        .wb_valid(wb_valid), .wb_rt_addr(wb_rt_addr), .wb_data(wb_data), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [RT_W-1:0]   rt;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // writeback monitor plus per-cycle interface invariants
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (in_ready !== !stall) begin
                bad++;
                $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !stall);
            end
`ifndef BYTE_PIPE_FWD_EN
            total++;
            if (fw_valid !== '0 || fw_rt_addr !== '0 || fw_data !== '0) begin
                bad++;
                $display("FAIL fw_zero cyc=%0d got fw_valid=%b", cyc, fw_valid);
            end
`endif
            if (wb_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected cyc=%0d got rt=%0d", cyc, wb_rt_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.due !== cyc || e.rt !== wb_rt_addr || e.data !== wb_data) begin
                        bad++;
                        $display("FAIL wb_match cyc=%0d got rt=%0d data=%h want due=%0d rt=%0d data=%h",
                                 cyc, wb_rt_addr, wb_data, e.due, e.rt, e.data);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL wb_missing cyc=%0d got wb_valid=%b want rt=%0d due=%0d",
                         cyc, wb_valid, e.rt, e.due);
            end
        end
    end

    // drive one cycle of inputs, then advance to just after the next edge
    task automatic drive(input logic v, input logic wr, input logic [RT_W-1:0] rt,
                         input logic [DATA_W-1:0] d, input logic st, input logic fl);
        in_valid = v; in_reg_wr = wr; in_rt_addr = rt; in_result = d;
        stall = st; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic push(input int due, input logic [RT_W-1:0] rt, input logic [DATA_W-1:0] d);
        exp_t e;
        e.due = due; e.rt = rt; e.data = d;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if (wb_valid !== 1'b0 || inflight !== 3'd0 || fw_valid !== '0) begin
            bad++;
            $display("FAIL reset_state got wb_valid=%b inflight=%0d fw_valid=%b want 0/0/0",
                     wb_valid, inflight, fw_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [DATA_W-1:0] d;
        d = {16{8'h01}};
        push(cyc + LAT, 7'd5, d);
        drive(1'b1, 1'b1, 7'd5, d, 1'b0, 1'b0);
        total++;
        if (inflight !== 3'd1) begin
            bad++;
            $display("FAIL single_inflight got=%0d want=1", inflight);
        end
        idle(LAT + 2);
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            push(cyc + LAT, RT_W'(i), {16{8'(8'hA0 + i)}});
            drive(1'b1, 1'b1, RT_W'(i), {16{8'(8'hA0 + i)}}, 1'b0, 1'b0);
        end
        total++;
        if (cyc !== c0 + 4 || inflight !== 3'd4) begin
            bad++;
            $display("FAIL b2b_inflight got=%0d want=4 (cyc %0d)", inflight, cyc - c0);
        end
        idle(LAT + 2);
    endtask

    task automatic test_stall;
        logic [DATA_W-1:0] d;
        d = {8{16'hBEEF}};
        push(cyc + LAT + 2, 7'd9, d);
        drive(1'b1, 1'b1, 7'd9, d, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            // issue attempted under stall must be dropped
            in_valid = 1'b1; in_reg_wr = 1'b1; in_rt_addr = 7'd20; in_result = '1;
            stall = 1'b1; flush = 1'b0;
            #1;
            total++;
            if (in_ready !== 1'b0 || inflight !== 3'd1) begin
                bad++;
                $display("FAIL stall_hold got in_ready=%b inflight=%0d want 0/1", in_ready, inflight);
            end
            @(posedge clk); #1;
        end
        idle(LAT + 3);
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, RT_W'(10 + i), {16{8'h55}}, 1'b0, 1'b0);
        total++;
        if (inflight !== 3'd3) begin
            bad++;
            $display("FAIL flush_pre got inflight=%0d want=3", inflight);
        end
        drive(1'b1, 1'b1, 7'd13, '1, 1'b1, 1'b1);
        total++;
        if (inflight !== 3'd0) begin
            bad++;
            $display("FAIL flush_clear got inflight=%0d want=0", inflight);
        end
        idle(LAT + 2);
        total++;
        if (inflight !== 3'd0) begin
            bad++;
            $display("FAIL flush_after got inflight=%0d want=0", inflight);
        end
    endtask

    task automatic test_no_wr;
        drive(1'b1, 1'b0, 7'd33, {16{8'h77}}, 1'b0, 1'b0);
        total++;
        if (inflight !== 3'd1 || fw_valid !== '0) begin
            bad++;
            $display("FAIL nowr_count got inflight=%0d fw_valid=%b want 1/0", inflight, fw_valid);
        end
        for (int i = 0; i < LAT + 1; i++) begin
            total++;
            if (wb_valid !== 1'b0 || fw_valid !== '0) begin
                bad++;
                $display("FAIL nowr_wb got wb_valid=%b fw_valid=%b want 0/0", wb_valid, fw_valid);
            end
            idle(1);
        end
        total++;
        if (inflight !== 3'd0) begin
            bad++;
            $display("FAIL nowr_drain got inflight=%0d want=0", inflight);
        end
    endtask

    task automatic test_reset_mid;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, RT_W'(40 + i), {16{8'h3C}}, 1'b0, 1'b0);
        total++;
        if (inflight !== 3'd3) begin
            bad++;
            $display("FAIL rstmid_pre got inflight=%0d want=3", inflight);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (wb_valid !== 1'b0 || inflight !== 3'd0 || fw_valid !== '0) begin
            bad++;
            $display("FAIL rstmid_clear got wb_valid=%b inflight=%0d fw_valid=%b want 0/0/0",
                     wb_valid, inflight, fw_valid);
        end
        #1;
        rst_n = 1'b1;
        // first capture lands on the first edge after release
        d = {4{32'hC0FFEE11}};
        push(cyc + LAT, 7'd50, d);
        drive(1'b1, 1'b1, 7'd50, d, 1'b0, 1'b0);
        total++;
        if (inflight !== 3'd1) begin
            bad++;
            $display("FAIL rstmid_capture got inflight=%0d want=1", inflight);
        end
        idle(LAT + 2);
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_no_wr();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
